// File: rtl/pot_weight_encoder.sv
// Iterative signed-weight to power-of-two code encoder: scans the magnitude MSB-first,
// rounds to the nearest power of two (ties up), and reports zero and saturation.
module pot_weight_encoder #(
    parameter int IN_WIDTH         = 8,
    parameter int WEIGHT_BIT_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [IN_WIDTH-1:0]         in_weight,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WEIGHT_BIT_WIDTH-1:0] out_code,
    output logic                        out_zero,
    output logic                        out_sat,
    output logic                        out_valid,
    input  logic                        out_ready
);
    localparam int MAX_EXP = 2**(WEIGHT_BIT_WIDTH-1) - 1;
    localparam int IDX_W   = $clog2(IN_WIDTH);
    localparam int EXP_W   = IDX_W + 1;
    localparam int FLD_W   = WEIGHT_BIT_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic                 sign_r;
    logic [IN_WIDTH-1:0]  mag_r;
    logic [IDX_W-1:0]     idx_r;
    logic                 load_s;
    logic                 finish_s;
    logic                 rnd_s;
    logic [EXP_W-1:0]     exp_s;
    logic                 sat_s;
    logic [FLD_W-1:0]     exp_field_s;
    logic [IN_WIDTH-1:0]  abs_s;

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == OUT);

    // Next-state decode and handshake strobes.
    always_comb begin
        state_s  = state_r;
        load_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = SCAN;
                    load_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                // Stop at the leading one, or at bit 0 when nothing was found.
                if (mag_r[idx_r] || (idx_r == {IDX_W{1'b0}})) begin
                    state_s  = OUT;
                    finish_s = 1'b1;
                end else begin
                    state_s = SCAN;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Magnitude, rounding bit and clamped exponent field for the current scan position.
    always_comb begin
        abs_s = in_weight;
        if (in_weight[IN_WIDTH-1]) begin
            abs_s = ~in_weight + IN_WIDTH'(1);
        end else begin
            abs_s = in_weight;
        end
        rnd_s = 1'b0;
        if (idx_r != {IDX_W{1'b0}}) begin
            rnd_s = mag_r[idx_r - IDX_W'(1)];
        end else begin
            rnd_s = 1'b0;
        end
        exp_s = EXP_W'(idx_r) + EXP_W'(rnd_s);
        sat_s = (int'(exp_s) > MAX_EXP);
        exp_field_s = FLD_W'(exp_s);
        if (sat_s) begin
            exp_field_s = {FLD_W{1'b1}};
        end else begin
            exp_field_s = FLD_W'(exp_s);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, scan index and registered result fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r   <= 1'b0;
            mag_r    <= {IN_WIDTH{1'b0}};
            idx_r    <= {IDX_W{1'b0}};
            out_code <= {WEIGHT_BIT_WIDTH{1'b0}};
            out_zero <= 1'b0;
            out_sat  <= 1'b0;
        end else begin
            if (load_s) begin
                sign_r <= in_weight[IN_WIDTH-1];
                mag_r  <= abs_s;
                idx_r  <= IDX_W'(IN_WIDTH - 1);
            end else if ((state_r == SCAN) && !finish_s) begin
                idx_r <= idx_r - IDX_W'(1);
            end
            if (finish_s) begin
                if (!mag_r[idx_r]) begin
                    out_code <= {WEIGHT_BIT_WIDTH{1'b0}};
                    out_zero <= 1'b1;
                    out_sat  <= 1'b0;
                end else begin
                    out_code <= {sign_r, exp_field_s};
                    out_zero <= 1'b0;
                    out_sat  <= sat_s;
                end
            end else if ((state_r == OUT) && out_ready) begin
                out_code <= {WEIGHT_BIT_WIDTH{1'b0}};
                out_zero <= 1'b0;
                out_sat  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pot_weight_encoder.sv
// Directed bench for pot_weight_encoder: an arithmetic reference model plus a per-cycle
// compare process, pinned by hand-computed expectations for each applied weight.
module tb_pot_weight_encoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_weight = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] out_code;
    logic       out_zero, out_sat, out_valid;
    logic       out_ready = 1'b1;

    logic [9:0] w10 = 10'd0;
    logic       v10 = 1'b0;
    logic       r10;
    logic [3:0] c10;
    logic       z10, s10, ov10;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    logic ev;

    typedef struct {
        logic [3:0] code;
        logic       zero;
        logic       sat;
        int         acc;
        int         lat;
    } exp_t;
    exp_t q[$];

    pot_weight_encoder #(.IN_WIDTH(8), .WEIGHT_BIT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_weight(in_weight), .in_valid(in_valid),
        .in_ready(in_ready), .out_code(out_code), .out_zero(out_zero),
        .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready));

    pot_weight_encoder #(.IN_WIDTH(10), .WEIGHT_BIT_WIDTH(4)) dut10 (
        .clk(clk), .rst_n(rst_n), .in_weight(w10), .in_valid(v10),
        .in_ready(r10), .out_code(c10), .out_zero(z10),
        .out_sat(s10), .out_valid(ov10), .out_ready(1'b1));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Nearest power of two in the linear domain, ties rounding up.
    function automatic void model(input int w, input int inw, output logic [3:0] code,
                                  output logic z, output logic s, output int lat);
        int mag;
        int p;
        int e;
        mag = (w < 0) ? -w : w;
        p = 0;
        if (mag == 0) begin
            code = 4'd0; z = 1'b1; s = 1'b0; lat = inw;
            return;
        end
        while ((2 ** (p + 1)) <= mag) p++;
        e = (2 * mag >= 3 * (2 ** p)) ? p + 1 : p;
        z = 1'b0;
        s = (e > 7);
        if (s) e = 7;
        code = {(w < 0), e[2:0]};
        lat = inw - p;
    endfunction

    // Per-cycle comparison of the 8-bit instance against the expectation queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_code", out_code, 0);
            chk("rst_out_zero", out_zero, 0);
            chk("rst_out_sat", out_sat, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid10", ov10, 0);
        end else begin
            ev = (q.size() > 0) && ((cyc - q[0].acc) >= q[0].lat);
            chk("in_ready", in_ready, (q.size() == 0));
            chk("out_valid", out_valid, ev);
            if (ev && out_valid) begin
                chk("out_code", out_code, q[0].code);
                chk("out_zero", out_zero, q[0].zero);
                chk("out_sat", out_sat, q[0].sat);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic apply(input int w, input logic [3:0] ecode, input logic ez,
                         input logic es, input int elat);
        logic [3:0] code;
        logic z, s;
        int lat;
        int t;
        model(w, 8, code, z, s, lat);
        chk("model_code", code, ecode);
        chk("model_zero", z, ez);
        chk("model_sat", s, es);
        chk("model_lat", lat, elat);
        @(negedge clk);
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        in_weight = w[7:0];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        q.push_back('{code, z, s, cyc, lat});
        in_valid = 1'b0;
        in_weight = 8'hA5;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q.size() > 0) begin
            chk("drain_timeout", 0, 1);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic apply10(input int w, input logic [3:0] ecode, input logic es, input int elat);
        logic [3:0] code;
        logic z, s;
        int lat;
        int acc;
        int t;
        model(w, 10, code, z, s, lat);
        chk("model10_code", code, ecode);
        chk("model10_sat", s, es);
        chk("model10_lat", lat, elat);
        @(negedge clk);
        chk("in_ready10", r10, 1);
        w10 = w[9:0];
        v10 = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        v10 = 1'b0;
        w10 = 10'h155;
        t = 0;
        @(negedge clk);
        while (!ov10 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("lat10", cyc - acc, lat);
        chk("out_code10", c10, code);
        chk("out_zero10", z10, z);
        chk("out_sat10", s10, s);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        apply(12, 4'b0100, 1'b0, 1'b0, 5);    drain();
        apply(-5, 4'b1010, 1'b0, 1'b0, 6);    drain();
        apply(-6, 4'b1011, 1'b0, 1'b0, 6);    drain();
        apply(-128, 4'b1111, 1'b0, 1'b0, 1);  drain();
        apply(127, 4'b0111, 1'b0, 1'b0, 2);   drain();
        apply(0, 4'b0000, 1'b1, 1'b0, 8);     drain();
        apply(1, 4'b0000, 1'b0, 1'b0, 8);     drain();
        apply(-1, 4'b1000, 1'b0, 1'b0, 8);    drain();
        apply(3, 4'b0010, 1'b0, 1'b0, 7);     drain();
        apply(-2, 4'b1001, 1'b0, 1'b0, 7);    drain();
        apply(64, 4'b0110, 1'b0, 1'b0, 2);    drain();
        apply(96, 4'b0111, 1'b0, 1'b0, 2);    drain();

        // Downstream back-pressure: result must hold while out_ready is low.
        @(posedge clk);
        #1 out_ready = 1'b0;
        apply(12, 4'b0100, 1'b0, 1'b0, 5);
        begin
            int t;
            t = 0;
            while (!out_valid && t < 50) begin
                @(posedge clk);
                t++;
            end
            chk("hold_valid_seen", out_valid, 1);
        end
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Reset in the middle of a scan aborts the operation.
        apply(5, 4'b0010, 1'b0, 1'b0, 6);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_code", out_code, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_zero", out_zero, 0);
        chk("midrst_out_sat", out_sat, 0);
        q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        apply(12, 4'b0100, 1'b0, 1'b0, 5);    drain();
        apply(-100, 4'b1111, 1'b0, 1'b0, 2);  drain();

        apply10(384, 4'b0111, 1'b1, 2);
        apply10(-512, 4'b1111, 1'b1, 1);
        apply10(6, 4'b0011, 1'b0, 8);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
